// File: rtl/minirv_mem_pkg.sv
// Shared types and access-size encodings for the miniRV memory subsystem.
package minirv_mem_pkg;

    localparam logic [1:0] MASK_B = 2'b00;
    localparam logic [1:0] MASK_H = 2'b01;
    localparam logic [1:0] MASK_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_D
    } arb_state_t;

endpackage

// File: rtl/mem_lane_gen.sv
// Byte-enable and write-data lane replication from the decoder's size mask.
module mem_lane_gen
    import minirv_mem_pkg::*;
(
    input  logic [1:0]  mask,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep
);

    always_comb begin
        be        = '0;
        wdata_rep = wdata;
        case (mask)
            MASK_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            MASK_H: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
            end
            // MASK_W and the reserved 2'b11 both act as a full word
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
        if (!we) be = '0;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (fetch, load/store) arbiter onto one variable-latency memory bus.
module mem_arbiter
    import minirv_mem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        if_flush_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [1:0]  d_mask_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_t  state;
    logic [3:0]  starve_cnt;
    logic        killed;
    logic [31:0] rdata;

    logic        starved;
    logic        d_win;
    logic        if_win;
    logic [31:0] sel_addr;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;

    // Grants are gated by reset so every output reads 0 while rst_ni is low
    always_comb begin
        starved  = (starve_cnt == STARVE_LIM) && if_req_i;
        d_win    = rst_ni && (state == IDLE) && d_req_i && !starved;
        if_win   = rst_ni && (state == IDLE) && if_req_i && !d_win;
        sel_addr = d_win ? d_addr_i : if_addr_i;
    end

    assign if_gnt_o   = if_win;
    assign d_gnt_o    = d_win;
    assign if_rdata_o = rdata;
    assign d_rdata_o  = rdata;

    mem_lane_gen u_lane_gen (
        .mask      (d_mask_i),
        .addr_lo   (sel_addr[1:0]),
        .wdata     (d_wdata_i),
        .we        (d_win && d_we_i),
        .be        (lane_be),
        .wdata_rep (lane_wdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            killed      <= 1'b0;
            rdata       <= '0;
            if_rvalid_o <= 1'b0;
            d_rvalid_o  <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_be_o    <= '0;
        end else begin
            if_rvalid_o <= 1'b0;
            d_rvalid_o  <= 1'b0;

            if (!if_req_i || if_win) begin
                starve_cnt <= '0;
            end else if (d_win && (starve_cnt != STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end

            case (state)
                IDLE: begin
                    killed <= 1'b0;
                    if (d_win || if_win) begin
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= d_win && d_we_i;
                        bus_addr_o  <= {sel_addr[31:2], 2'b00};
                        bus_wdata_o <= lane_wdata;
                        bus_be_o    <= lane_be;
                        state       <= d_win ? BUSY_D : BUSY_IF;
                    end
                end
                BUSY_IF: begin
                    if (if_flush_i) killed <= 1'b1;
                    // A flush on the ack cycle itself must still suppress the pulse
                    if (bus_ack_i) begin
                        bus_req_o   <= 1'b0;
                        rdata       <= bus_rdata_i;
                        if_rvalid_o <= !(killed || if_flush_i);
                        killed      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                BUSY_D: begin
                    if (bus_ack_i) begin
                        bus_req_o  <= 1'b0;
                        rdata      <= bus_rdata_i;
                        d_rvalid_o <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, single-slave memory arbiter for the multi-cycle miniRV core. It shares one single-port, variable-latency memory bus between the instruction-fetch unit and the load/store unit. Data accesses have fixed priority, backed by a starvation guard for fetch. Write accesses get byte-lane enables derived from the mask encoding the decoder already produces.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while fetch is waiting; range 1–15.

Ports:
- clk_i  in  1  core clock; all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch request; held until if_gnt_o
- if_addr_i  in  32  fetch address
- if_flush_i  in  1  discard the outstanding fetch response
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch data valid, one-cycle pulse
- if_rdata_o  out  32  fetch data
- d_req_i  in  1  data request; held with its fields until d_gnt_o
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  32  data address
- d_wdata_i  in  32  store data, right-aligned
- d_mask_i  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
- d_gnt_o  out  1  data request accepted this cycle
- d_rvalid_o  out  1  data response pulse; loads and stores both get one
- d_rdata_o  out  32  raw aligned word; lane extraction and sign extension stay in the LSU
- bus_req_o  out  1  bus request; held until bus_ack_i
- bus_we_o  out  1  bus write
- bus_addr_o  out  32  word-aligned address {addr[31:2], 2'b00}
- bus_wdata_o  out  32  lane-replicated write data
- bus_be_o  out  4  byte enables; 4'b0000 on reads
- bus_ack_i  in  1  bus completion; read data valid in the same cycle
- bus_rdata_i  in  32  bus read data

## Operation
FSM states: IDLE, BUSY_IF, BUSY_D.

IDLE:
- Arbitration is combinational.
- d_req_i wins, unless starve_cnt == STARVE_MAX and if_req_i = 1; then fetch wins.
- The winner's gnt is high that cycle. Address, we, wdata and be are latched. The state moves to BUSY_IF or BUSY_D.
- Only one gnt is ever high in a cycle.

starve_cnt (4 bits):
- Increments on each data grant while if_req_i = 1.
- Clears on a fetch grant, or on any cycle with if_req_i = 0.
- Saturates at STARVE_MAX.

BUSY_x:
- bus_req_o = 1 with the latched fields until bus_ack_i.
- On ack: bus_rdata_i is registered, the matching rvalid pulses the next cycle, and the state returns to IDLE.

Byte enables and write data:
- Byte: be = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
- Half: be = 4'b0011 << {addr[1], 1'b0}; wdata = {2{wdata[15:0]}}; addr[0] is ignored.
- Word: be = 4'b1111; addr[1:0] are ignored.
- Reads: be = 4'b0000.

Flush:
- A fetch_killed flag is set if if_flush_i = 1 in any cycle of BUSY_IF, including the ack cycle.
- A killed transaction still completes on the bus, but its if_rvalid_o is suppressed.
- The flag clears on return to IDLE.
- if_flush_i has no effect in IDLE or BUSY_D.

Reset, mid-transaction included:
- The FSM goes to IDLE and all outputs go to 0.
- Any pending ack is abandoned. The bus slave must accept a dropped request.

## Timing
- Cycle 0: request and gnt. Cycle 1: bus_req_o = 1, first possible ack. Cycle 2: rvalid.
- Minimum latency from request to rvalid is 2 cycles. Each wait state on the bus adds 1.
- The IDLE state coincides with the rvalid cycle, so a new gnt can be issued in that same cycle.
- Peak throughput is one transaction per 2 cycles.
- bus_* outputs are registered and stay stable while bus_req_o = 1.
- gnt_o is combinational from req_i in IDLE.
- If both masters request on the same edge: data wins, fetch stays pending and gets its gnt no later than STARVE_MAX + 1 grants later.

## Structure
- Package minirv_mem_pkg holds:
  - MASK_B = 2'b00, MASK_H = 2'b01, MASK_W = 2'b10;
  - arb_state_t {IDLE, BUSY_IF, BUSY_D}.
- One sub-module, mem_lane_gen: combinational (mask, addr[1:0], wdata, we) -> (be, replicated wdata).
- mem_lane_gen is reused later by the LSU.

## Test plan
- Single fetch, ack in cycle 1 -> if_gnt_o in cycle 0, if_rvalid_o in cycle 2 with bus_rdata_i, bus_be_o = 0.
- Store byte: d_addr_i = 0x1003, d_wdata_i = 0xAB, mask 00 -> bus_addr_o = 0x1000, bus_be_o = 4'b1000, bus_wdata_o = 0xABABABAB. Repeat with a half store at 0x1002 -> bus_be_o = 4'b1100.
- Both requests held continuously, STARVE_MAX = 4 -> grant sequence D, D, D, D, IF, D, D, D, D, IF, ...
- Fetch with 3 wait states and if_flush_i pulsed in wait cycle 2 -> bus ack still consumed, no if_rvalid_o, next fetch granted normally.
- Back-to-back loads, zero wait -> d_gnt_o in cycles 0, 2, 4, each coinciding with the previous d_rvalid_o.
- rst_ni low during BUSY_D with bus_req_o = 1 -> all outputs 0 immediately. After release, a fresh fetch completes with no stale d_rvalid_o.
